// File: rtl/parser_pkg.sv
// Shared types and sizing constants for the parser pipeline front stage.
package parser_pkg;

    localparam int unsigned DATA_WIDTH        = 256;
    localparam int unsigned HEAD_WIDTH        = 1024;
    localparam int unsigned META_WIDTH        = 512;
    localparam int unsigned TAG_WIDTH         = 8;
    localparam int unsigned ID_WIDTH          = TAG_WIDTH - 1;
    localparam int unsigned HEAD_BEATS        = HEAD_WIDTH / DATA_WIDTH;
    localparam int unsigned CNT_WIDTH         = $clog2(HEAD_BEATS + 1);

    // Codebase-wide parser layer geometry
    localparam int unsigned TYPE_NUM          = 4;
    localparam int unsigned TYPE_OFFSET_WIDTH = 8;
    localparam int unsigned KEY_FILED_NUM     = 8;
    localparam int unsigned KEY_OFFSET_WIDTH  = 7;
    localparam int unsigned HEAD_SHIFT_WIDTH  = 6;
    localparam int unsigned META_SHIFT_WIDTH  = 6;
    localparam int unsigned TYPE_BUS_WIDTH    = TYPE_NUM * TYPE_OFFSET_WIDTH;
    localparam int unsigned KEY_BUS_WIDTH     = KEY_FILED_NUM * (KEY_OFFSET_WIDTH + 1);

    // Tag carried alongside head/meta: valid strobe plus packet id
    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
    } tag_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_e;

endpackage

// File: rtl/parser_head_builder.sv
// Front stage of the parser pipeline: forwards ingress beats tagged with a
// packet id and captures the first HEAD_BEATS beats of each packet into a
// head vector, emitting one tagged head/meta pulse per packet.
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_data_valid/i_data/i_data_last ingress beat stream (first byte at MSB)
//   o_data_ready                   ingress ready (follows i_pkt_ready)
//   o_pkt_valid/data/last/id       payload pass-through plus packet id
//   i_pkt_ready                    payload sink ready
//   i_init_type/key_offset         seed offsets for parser layer 0
//   o_type/key_offset              seed offsets registered with the head
//   o_headShift/o_metaShift        constant zero shifts
//   o_head, o_meta                 {tag, head} and {tag, zero meta}
module parser_head_builder
    import parser_pkg::*;
(
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_data_valid,
    input  logic [DATA_WIDTH-1:0]                i_data,
    input  logic                                 i_data_last,
    output logic                                 o_data_ready,
    output logic                                 o_pkt_valid,
    output logic [DATA_WIDTH-1:0]                o_pkt_data,
    output logic                                 o_pkt_last,
    output logic [ID_WIDTH-1:0]                  o_pkt_id,
    input  logic                                 i_pkt_ready,
    input  logic [TYPE_BUS_WIDTH-1:0]            i_init_type_offset,
    input  logic [KEY_BUS_WIDTH-1:0]             i_init_key_offset,
    output logic [TYPE_BUS_WIDTH-1:0]            o_type_offset,
    output logic [KEY_BUS_WIDTH-1:0]             o_key_offset,
    output logic [HEAD_SHIFT_WIDTH-1:0]          o_headShift,
    output logic [META_SHIFT_WIDTH-1:0]          o_metaShift,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0]      o_head,
    output logic [META_WIDTH+TAG_WIDTH-1:0]      o_meta
);

    state_e                      r_state;
    state_e                      w_next_state;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic [ID_WIDTH-1:0]         r_id;
    logic [HEAD_WIDTH-1:0]       r_head;
    logic [HEAD_WIDTH-1:0]       r_out_head;
    logic [HEAD_WIDTH-1:0]       w_head_next;
    tag_t                        r_tag;
    logic [TYPE_BUS_WIDTH-1:0]   r_type_offset;
    logic [KEY_BUS_WIDTH-1:0]    r_key_offset;
    logic                        w_accept;
    logic                        w_emit;

    // Combinational pass-through; no ingress buffering
    assign o_data_ready = i_pkt_ready;
    assign o_pkt_valid  = i_data_valid;
    assign o_pkt_data   = i_data;
    assign o_pkt_last   = i_data_last;
    assign o_pkt_id     = r_id;
    assign w_accept     = i_data_valid & i_pkt_ready;

    assign o_headShift   = '0;
    assign o_metaShift   = '0;
    assign o_type_offset = r_type_offset;
    assign o_key_offset  = r_key_offset;
    assign o_head        = {r_tag, r_out_head};
    assign o_meta        = {r_tag, {META_WIDTH{1'b0}}};

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, emit decision and head-with-current-beat
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_head_next  = r_head;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    // SOP starts from a cleared head so short packets stay zero-padded
                    w_head_next = '0;
                    w_head_next[HEAD_WIDTH-1 -: DATA_WIDTH] = i_data;
                    if (i_data_last || (HEAD_BEATS == 1)) begin
                        w_emit       = 1'b1;
                        w_next_state = i_data_last ? IDLE : DRAIN;
                    end else begin
                        w_next_state = COLLECT;
                    end
                end
                COLLECT: begin
                    for (int s = 1; s < HEAD_BEATS; s++) begin
                        if (r_cnt == CNT_WIDTH'(s)) begin
                            w_head_next[HEAD_WIDTH-1-s*DATA_WIDTH -: DATA_WIDTH] = i_data;
                        end
                    end
                    if (i_data_last || (r_cnt == CNT_WIDTH'(HEAD_BEATS - 1))) begin
                        w_emit       = 1'b1;
                        w_next_state = i_data_last ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (i_data_last) begin
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Head capture, packet id and emit register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt         <= '0;
            r_id          <= '0;
            r_head        <= '0;
            r_out_head    <= '0;
            r_tag         <= '0;
            r_type_offset <= '0;
            r_key_offset  <= '0;
        end else begin
            r_tag.valid <= w_emit;
            if (w_accept) begin
                if (r_state == IDLE) begin
                    r_head <= w_head_next;
                    r_cnt  <= CNT_WIDTH'(1);
                end else if (r_state == COLLECT) begin
                    r_head <= w_head_next;
                    r_cnt  <= r_cnt + 1'b1;
                end
                if (i_data_last) begin
                    r_id <= r_id + 1'b1;
                end
            end
            // Emitted tag carries the pre-increment id
            if (w_emit) begin
                r_tag.id      <= r_id;
                r_out_head    <= w_head_next;
                r_type_offset <= i_init_type_offset;
                r_key_offset  <= i_init_key_offset;
            end
        end
    end

endmodule

// File: tb/tb_parser_head_builder.sv
// Bench for parser_head_builder: randomized packet stream with stalls and
// mid-packet resets, checked every cycle against a packet-level model, plus
// literal expectations on hand-built packets.
module tb_parser_head_builder;
    import parser_pkg::*;

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned HW = HEAD_WIDTH;
    localparam int unsigned MW = META_WIDTH;
    localparam int unsigned TW = TAG_WIDTH;

    logic                        i_clk;
    logic                        i_rst_n;
    logic                        i_data_valid;
    logic [DW-1:0]               i_data;
    logic                        i_data_last;
    logic                        o_data_ready;
    logic                        o_pkt_valid;
    logic [DW-1:0]               o_pkt_data;
    logic                        o_pkt_last;
    logic [ID_WIDTH-1:0]         o_pkt_id;
    logic                        i_pkt_ready;
    logic [TYPE_BUS_WIDTH-1:0]   i_init_type_offset;
    logic [KEY_BUS_WIDTH-1:0]    i_init_key_offset;
    logic [TYPE_BUS_WIDTH-1:0]   o_type_offset;
    logic [KEY_BUS_WIDTH-1:0]    o_key_offset;
    logic [HEAD_SHIFT_WIDTH-1:0] o_headShift;
    logic [META_SHIFT_WIDTH-1:0] o_metaShift;
    logic [HW+TW-1:0]            o_head;
    logic [MW+TW-1:0]            o_meta;

    parser_head_builder dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_data_valid       (i_data_valid),
        .i_data             (i_data),
        .i_data_last        (i_data_last),
        .o_data_ready       (o_data_ready),
        .o_pkt_valid        (o_pkt_valid),
        .o_pkt_data         (o_pkt_data),
        .o_pkt_last         (o_pkt_last),
        .o_pkt_id           (o_pkt_id),
        .i_pkt_ready        (i_pkt_ready),
        .i_init_type_offset (i_init_type_offset),
        .i_init_key_offset  (i_init_key_offset),
        .o_type_offset      (o_type_offset),
        .o_key_offset       (o_key_offset),
        .o_headShift        (o_headShift),
        .o_metaShift        (o_metaShift),
        .o_head             (o_head),
        .o_meta             (o_meta)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cycles = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Wide compare; reports only the first differing 64-bit word
    task automatic chk_wide(input string nm, input logic [HW+TW-1:0] act, input logic [HW+TW-1:0] exp);
        bit shown;
        shown = 0;
        checks++;
        if (act !== exp) begin
            errors++;
            for (int w = (HW + TW + 63) / 64 - 1; w >= 0; w--) begin
                if (!shown && (act[w*64 +: 64] !== exp[w*64 +: 64])) begin
                    shown = 1;
                    $display("FAIL %s: word %0d got %h expected %h (t=%0t)",
                             nm, w, act[w*64 +: 64], exp[w*64 +: 64], $time);
                end
            end
        end
    endtask

    function automatic logic [DW-1:0] rnd_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- packet-level reference model ----------------
    logic [DW-1:0]             beats_q[$];
    bit                        in_pkt;
    bit                        emitted;
    int unsigned               m_id;
    bit                        exp_valid;
    logic [HW-1:0]             exp_head;
    int unsigned               exp_id;
    logic [TYPE_BUS_WIDTH-1:0] exp_type;
    logic [KEY_BUS_WIDTH-1:0]  exp_key;
    bit                        started;

    initial begin
        in_pkt = 0; emitted = 0; m_id = 0; exp_valid = 0; started = 0;
        exp_head = '0; exp_id = 0; exp_type = '0; exp_key = '0;
    end

    // Head = first beats of the packet laid out MSB-first, zero-padded
    function automatic logic [HW-1:0] build_head();
        logic [HW-1:0] h;
        h = '0;
        foreach (beats_q[i]) h = h | ({beats_q[i], {(HW-DW){1'b0}}} >> (i * DW));
        return h;
    endfunction

    always @(posedge i_clk) begin
        started = 1;
        cycles++;
        if (!i_rst_n) begin
            beats_q.delete();
            in_pkt = 0; emitted = 0; m_id = 0; exp_valid = 0;
        end else begin
            exp_valid = 0;
            if (i_data_valid && i_pkt_ready) begin
                if (!in_pkt) begin
                    beats_q.delete();
                    in_pkt  = 1;
                    emitted = 0;
                end
                if (beats_q.size() < HEAD_BEATS) beats_q.push_back(i_data);
                if (!emitted && (beats_q.size() == HEAD_BEATS || i_data_last)) begin
                    exp_valid = 1;
                    exp_head  = build_head();
                    exp_id    = m_id;
                    exp_type  = i_init_type_offset;
                    exp_key   = i_init_key_offset;
                    emitted   = 1;
                end
                if (i_data_last) begin
                    m_id   = (m_id + 1) % (1 << ID_WIDTH);
                    in_pkt = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge i_clk) begin
        if (started) begin
            chk("ready", 64'(o_data_ready), 64'(i_pkt_ready));
            chk("pkt_valid", 64'(o_pkt_valid), 64'(i_data_valid));
            chk("pkt_last", 64'(o_pkt_last), 64'(i_data_last));
            chk_wide("pkt_data", (HW+TW)'(o_pkt_data), (HW+TW)'(i_data));
            chk("pkt_id", 64'(o_pkt_id), 64'(m_id));
            chk("head_tag_valid", 64'(o_head[HW+TW-1]), 64'(exp_valid));
            chk("meta_tag_valid", 64'(o_meta[MW+TW-1]), 64'(exp_valid));
            chk("shifts", 64'({o_headShift, o_metaShift}), 64'(0));
            if (exp_valid) begin
                chk_wide("head", o_head, {1'b1, ID_WIDTH'(exp_id), exp_head});
                chk_wide("meta", (HW+TW)'(o_meta), (HW+TW)'({1'b1, ID_WIDTH'(exp_id), {MW{1'b0}}}));
                chk("type_off", 64'(o_type_offset), 64'(exp_type));
                chk("key_off", 64'(o_key_offset), 64'(exp_key));
            end
        end
    end

    always @(posedge i_clk) begin
        if (cycles > 80000) begin
            $display("FAIL watchdog: cycles %0d exceeded budget 80000", cycles);
            $fatal(1, "watchdog");
        end
    end

    // ---------------- stimulus ----------------
    // Present one beat until accepted; rnd adds random valid/ready stalls
    task automatic drive_beat(input logic [DW-1:0] d, input logic l, input bit rnd);
        bit done;
        done = 0;
        while (!done) begin
            i_data             = d;
            i_data_last        = l;
            i_data_valid       = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_pkt_ready        = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
            i_init_type_offset = TYPE_BUS_WIDTH'($urandom);
            i_init_key_offset  = KEY_BUS_WIDTH'({$urandom, $urandom});
            @(posedge i_clk);
            done = i_data_valid && i_pkt_ready;
            #1;
        end
    endtask

    task automatic idle(input int n);
        i_data_valid = 1'b0;
        i_data_last  = 1'b0;
        i_pkt_ready  = 1'b1;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    logic [DW-1:0] a, b, c, d, e;
    logic [DW-1:0] bs[6];
    int            len;

    initial begin
        i_rst_n = 1'b0; i_data_valid = 1'b0; i_data = '0; i_data_last = 1'b0;
        i_pkt_ready = 1'b1; i_init_type_offset = '0; i_init_key_offset = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_tag", 64'(o_head[HW+TW-1:HW]), 64'h00);
        chk("rst_offsets", 64'({o_type_offset, o_key_offset} != 0), 64'(0));
        chk("rst_pkt_id", 64'(o_pkt_id), 64'(0));

        // 4-beat packet fills the head exactly
        a = {8{32'hAAAA_0001}}; b = {8{32'hBBBB_0002}};
        c = {8{32'hCCCC_0003}}; d = {8{32'hDDDD_0004}};
        drive_beat(a, 0, 0); drive_beat(b, 0, 0); drive_beat(c, 0, 0); drive_beat(d, 1, 0);
        i_data_valid = 1'b0;
        @(negedge i_clk);
        chk_wide("t1_head", o_head, {8'h80, a, b, c, d});
        chk("t1_id", 64'(o_pkt_id), 64'(1));
        idle(2);

        // 2-beat packet: remaining slots zero
        drive_beat(a, 0, 0); drive_beat(b, 1, 0);
        i_data_valid = 1'b0;
        @(negedge i_clk);
        chk_wide("t2_head", o_head, {8'h81, a, b, 512'h0});
        idle(2);

        // 6-beat packet: emit after beat 4 only
        for (int i = 0; i < 6; i++) bs[i] = rnd_beat();
        for (int i = 0; i < 4; i++) drive_beat(bs[i], 0, 0);
        @(negedge i_clk);
        chk_wide("t3_head", o_head, {8'h82, bs[0], bs[1], bs[2], bs[3]});
        drive_beat(bs[4], 0, 0);
        drive_beat(bs[5], 1, 0);
        i_data_valid = 1'b0;
        @(negedge i_clk);
        chk("t3_no_second_emit", 64'(o_head[HW+TW-1]), 64'(0));
        idle(2);

        // three single-beat packets back to back
        for (int i = 0; i < 3; i++) begin
            e = rnd_beat();
            drive_beat(e, 1, 0);
            @(negedge i_clk);
            chk_wide("t4_head", o_head, {8'(8'h83 + i), e, 768'h0});
            chk("t4_pkt_id", 64'(o_pkt_id), 64'(4 + i));
        end
        idle(2);

        // stall mid-collect
        drive_beat(a, 0, 0); drive_beat(b, 0, 0);
        i_data_valid = 1'b1; i_data = c; i_pkt_ready = 1'b0;
        repeat (5) begin
            @(negedge i_clk);
            chk("t5_ready_low", 64'(o_data_ready), 64'(0));
            chk("t5_no_emit", 64'(o_head[HW+TW-1]), 64'(0));
        end
        drive_beat(c, 0, 0); drive_beat(d, 1, 0);
        i_data_valid = 1'b0;
        @(negedge i_clk);
        chk_wide("t5_head", o_head, {8'h86, a, b, c, d});
        idle(2);

        // reset mid-packet drops it and restarts ids
        drive_beat(a, 0, 0); drive_beat(b, 0, 0);
        pulse_reset();
        idle(1);
        e = rnd_beat();
        drive_beat(e, 1, 0);
        i_data_valid = 1'b0;
        @(negedge i_clk);
        chk_wide("t6_head", o_head, {8'h80, e, 768'h0});

        // remaining 127 packets wrap the id back to 0
        for (int i = 0; i < 127; i++) drive_beat(rnd_beat(), 1, 0);
        i_data_valid = 1'b0;
        @(negedge i_clk);
        chk("wrap_tag", 64'(o_head[HW+TW-1:HW]), 64'hFF);
        chk("wrap_pkt_id", 64'(o_pkt_id), 64'(0));
        idle(2);

        // randomized traffic with stalls, gaps and occasional resets
        for (int p = 0; p < 300; p++) begin
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 39) == 0) begin
                for (int k = 0; k < len; k++) drive_beat(rnd_beat(), 0, 1);
                pulse_reset();
            end else begin
                for (int k = 0; k < len; k++) drive_beat(rnd_beat(), (k == len - 1), 1);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
